// File: rtl/dff_bist_checker.sv
// BIST for a single-bit D flip-flop: drives an LFSR stream into d,
// checks q one cycle later, reports pass, error count and first bad index.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         run request, honoured only in IDLE or DONE
//   dut_d         registered stimulus to the flip-flop's d input
//   dut_q         flip-flop q output
//   busy          high while vectors are driven or being drained
//   done          level, high in DONE
//   pass          valid with done: err_count is zero
//   err_count     saturating mismatch count
//   first_err_idx vector index of the first mismatch (0 if none)
module dff_bist_checker #(
  parameter int          NUM_VECTORS = 16,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_err_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [7:0] SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic       ONE_VEC  = (NUM_VECTORS == 1);

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       vec_cnt_q, vec_cnt_d;
  logic             dut_d_q, dut_d_d;
  logic             exp_q;
  logic [1:0]       vld_q, vld_d;
  logic [7:0]       cmp_idx_q, cmp_idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       idx_q, idx_d;
  logic             pass_q, pass_d;

  logic drive;
  logic mismatch;

  // vld_q[1] marks that exp_q holds a vector whose flip-flop
  // capture is now visible on dut_q.
  assign mismatch = vld_q[1] & (dut_q ^ exp_q);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    vec_cnt_d = vec_cnt_q;
    dut_d_d   = 1'b0;
    drive     = 1'b0;
    cmp_idx_d = cmp_idx_q;
    err_d     = err_q;
    idx_d     = idx_q;
    pass_d    = pass_q;

    // Compare stage runs independently of the FSM.
    if (vld_q[1]) begin
      cmp_idx_d = cmp_idx_q + 8'd1;
    end
    if (mismatch) begin
      // err_q==0 means no earlier mismatch: the count never
      // wraps back to zero because it saturates.
      if (err_q == '0) begin
        idx_d = cmp_idx_q;
      end
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dut_d_d   = SEED[7];
          lfsr_d    = lfsr_step(SEED);
          vec_cnt_d = 8'd1;
          drive     = 1'b1;
          cmp_idx_d = 8'd0;
          err_d     = '0;
          idx_d     = 8'd0;
          pass_d    = 1'b0;
          state_d   = ONE_VEC ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        dut_d_d   = lfsr_q[7];
        lfsr_d    = lfsr_step(lfsr_q);
        vec_cnt_d = vec_cnt_q + 8'd1;
        drive     = 1'b1;
        if (vec_cnt_q == LAST_VEC) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last vector sits in the compare stage and nothing
        // follows it: this edge performs the final compare.
        if (vld_q == 2'b10) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    vld_d = {vld_q[0], drive};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      vec_cnt_q <= 8'd0;
      dut_d_q   <= 1'b0;
      exp_q     <= 1'b0;
      vld_q     <= 2'b00;
      cmp_idx_q <= 8'd0;
      err_q     <= '0;
      idx_q     <= 8'd0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      vec_cnt_q <= vec_cnt_d;
      dut_d_q   <= dut_d_d;
      exp_q     <= dut_d_q;
      vld_q     <= vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
    end
  end

  assign dut_d         = dut_d_q;
  assign busy          = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = idx_q;

endmodule

// File: tb/tb_dff_bist_checker.sv
// Scoreboard bench for dff_bist_checker: directed fault modes,
// expected run results queued at start and checked when done rises.
module tb_dff_bist_checker;

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [7:0] idx;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0;
  logic start3 = 1'b0;
  int   mode = 0;
  int   cyc = 0;

  int n_chk = 0;
  int n_fail = 0;

  exp_t q8[$];
  exp_t q3[$];

  logic       d8, q8_pin, busy8, done8, pass8;
  logic [7:0] err8, idx8;
  logic       d3, q3_pin, busy3, done3, pass3;
  logic [2:0] err3;
  logic [7:0] idx3;
  logic       ff8 = 1'b0;
  logic       ff3 = 1'b0;

  // v0..v15 for seed A5
  logic [15:0] vec_tab = 16'b1010_0101_0100_1110;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // flip-flop under test with selectable fault
  always @(posedge clk) ff8 <= d8;
  always @(posedge clk) ff3 <= d3;

  function automatic logic fault(input int m, input logic f);
    case (m)
      1: return 1'b0;
      2: return 1'b1;
      3: return ~f;
      default: return f;
    endcase
  endfunction

  assign q8_pin = fault(mode, ff8);
  assign q3_pin = fault(mode, ff3);

  dff_bist_checker #(
    .NUM_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start8),
    .dut_d(d8), .dut_q(q8_pin),
    .busy(busy8), .done(done8), .pass(pass8),
    .err_count(err8), .first_err_idx(idx8)
  );

  dff_bist_checker #(
    .NUM_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(3)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .dut_d(d3), .dut_q(q3_pin),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_idx(idx3)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitors: pop and compare when done rises
  logic dp8 = 1'b0;
  logic dp3 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done8 && !dp8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("pass8", {31'd0, pass8}, {31'd0, e.pass});
        chk("err8", {24'd0, err8}, {24'd0, e.err});
        chk("idx8", {24'd0, idx8}, {24'd0, e.idx});
        chk("done_cyc8", cyc, e.cyc);
      end
    end
    dp8 <= done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done3 && !dp3) begin
      if (q3.size() == 0) begin
        chk("unexpected_done3", 1, 0);
      end else begin
        e = q3.pop_front();
        chk("pass3", {31'd0, pass3}, {31'd0, e.pass});
        chk("err3", {29'd0, err3}, {24'd0, e.err});
        chk("idx3", {24'd0, idx3}, {24'd0, e.idx});
        chk("done_cyc3", cyc, e.cyc);
      end
    end
    dp3 <= done3;
  end

  // called at a negedge with start about to be sampled at next edge
  function automatic exp_t mk(input logic p, input logic [7:0] er,
                              input logic [7:0] ix);
    exp_t e;
    e.pass = p;
    e.err  = er;
    e.idx  = ix;
    e.cyc  = cyc + 1 + 17;
    return e;
  endfunction

  task automatic wait_done8(input int lim);
    int n = 0;
    while (!done8 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done8_timeout", {31'd0, done8}, 1);
    @(negedge clk);
  endtask

  task automatic wait_done3(input int lim);
    int n = 0;
    while (!done3 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done3_timeout", {31'd0, done3}, 1);
    @(negedge clk);
  endtask

  task automatic run8(input int m, input exp_t e);
    mode = m;
    start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(40);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dut_d", {31'd0, d8}, 0);
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_pass", {31'd0, pass8}, 0);
    chk("rst_err", {24'd0, err8}, 0);
    chk("rst_idx", {24'd0, idx8}, 0);
    chk("rst_done3", {31'd0, done3}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: ideal flip-flop, check stimulus stream
    mode = 0;
    start8 = 1'b1;
    q8.push_back(mk(1'b1, 8'd0, 8'd0));
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("vec%0d", k), {31'd0, d8},
          {31'd0, vec_tab[15-k]});
      chk("busy_run", {31'd0, busy8}, 1);
      @(negedge clk);
    end
    chk("drain_dut_d", {31'd0, d8}, 0);
    chk("drain_busy", {31'd0, busy8}, 1);
    wait_done8(10);
    chk("done_busy", {31'd0, busy8}, 0);

    // 2: stuck at 0
    run8(1, mk(1'b0, 8'd8, 8'd0));
    // 3: stuck at 1
    run8(2, mk(1'b0, 8'd8, 8'd1));

    // 4: inverted q, narrow counter saturates
    mode = 3;
    start3 = 1'b1;
    q3.push_back(mk(1'b0, 8'd7, 8'd0));
    @(negedge clk);
    start3 = 1'b0;
    wait_done3(40);

    // 5: reset at E8 aborts the run
    mode = 0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy8}, 0);
    chk("abort_done", {31'd0, done8}, 0);
    chk("abort_err", {24'd0, err8}, 0);
    chk("abort_dut_d", {31'd0, d8}, 0);
    chk("abort_idx", {24'd0, idx8}, 0);
    rst = 1'b0;
    @(negedge clk);
    run8(0, mk(1'b1, 8'd0, 8'd0));

    // 6: start held in RUN, then restart from DONE
    mode = 1;
    start8 = 1'b1;
    q8.push_back(mk(1'b0, 8'd8, 8'd0));
    repeat (12) @(negedge clk);
    chk("held_busy", {31'd0, busy8}, 1);
    start8 = 1'b0;
    wait_done8(40);
    chk("prev_err", {24'd0, err8}, 8);
    mode = 0;
    start8 = 1'b1;
    q8.push_back(mk(1'b1, 8'd0, 8'd0));
    @(negedge clk);
    start8 = 1'b0;
    chk("restart_err", {24'd0, err8}, 0);
    chk("restart_done", {31'd0, done8}, 0);
    chk("restart_busy", {31'd0, busy8}, 1);
    wait_done8(40);

    repeat (3) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q3_empty", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bist_checker.md
Name: dff_bist_checker

Overview:
- Synthesizable built-in self-test block for a single-bit D flip-flop with 1-cycle latency: q after edge n equals d before edge n.
- Drives an 8-bit LFSR pseudo-random bit stream into the flip-flop's d input and samples its q output.
- Compares q against the expected delayed stimulus, then reports pass/fail, a saturating error count and the index of the first mismatch.
- Sits beside the flip-flop under test; its outputs feed status registers or top-level debug pins.

Parameters:
- NUM_VECTORS, 16, number of stimulus bits driven per run (1..255).
- LFSR_SEED, 8'hA5, initial LFSR state. Must be nonzero; 0 is replaced by 8'h01.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request. Sampled only in IDLE or DONE.
- dut_d  output  1  registered stimulus to the flip-flop's d input.
- dut_q  input  1  flip-flop q output.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  level, high in DONE.
- pass  output  1  valid when done=1: err_count==0.
- err_count  output  ERR_W  mismatch count, saturating at all-ones.
- first_err_idx  output  8  vector index of the first mismatch. Holds 0 if there is no mismatch.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset state:
  - state=IDLE
  - dut_d=0, busy=0, done=0, pass=0
  - err_count=0, first_err_idx=0
  - LFSR=LFSR_SEED, compare pipeline cleared
- Reset mid-run aborts immediately to the reset state. No partial result is retained.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - fb = L[7]^L[5]^L[4]^L[3]; next = {L[6:0], fb}.
  - Vector k = bit 7 of LFSR state k; state 0 = seed.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with start=1, at edge E0:
  - Clear err_count, first_err_idx, done and pass.
  - Set dut_d=v0 and LFSR=state1.
  - Set vec_cnt=1 and go to RUN.
- RUN: each edge drives the next vector v(vec_cnt), advances the LFSR and increments vec_cnt. After v(NUM_VECTORS-1) is driven, go to DRAIN and set dut_d=0.
- Expected pipeline:
  - exp_reg <= dut_d every edge.
  - A 2-bit valid shift register tags driven vectors; a compare index counter tracks k.
  - Vector vk is driven after edge Ek, captured by the flip-flop at E(k+1), and compared at E(k+2): dut_q vs exp_reg.
- On a mismatch, err_count increments, saturating at 2^ERR_W-1. If this is the first mismatch of the run, first_err_idx <= k.
- DRAIN: waits for the final compare at E(NUM_VECTORS+1). On that edge go to DONE and set done=1 and pass=(final err_count==0), including the last compare.
- DONE holds all results until start or rst.
- start during RUN or DRAIN is ignored.
- start and rst on the same edge: rst wins.
- start in DONE begins a new run on the same edge. done drops after that edge.
- With the default seed, v0..v15 = 1,0,1,0,0,1,0,1,0,1,0,0,1,1,1,0, which has eight ones.

Test Plan:
1. Ideal DFF model, defaults, start pulsed at E0:
   - busy=1 after E0; dut_d shows v0..v15 on successive cycles.
   - done=1 after E17 with pass=1, err_count=0, first_err_idx=0.
2. dut_q stuck at 0 -> done after E17, pass=0, err_count=8, first_err_idx=0.
3. dut_q stuck at 1 -> err_count=8, first_err_idx=1, pass=0.
4. dut_q = ~dut_d delayed, with ERR_W=3 -> err_count saturates at 7, first_err_idx=0, pass=0.
5. rst asserted at E8 mid-run -> after E8: state IDLE, busy=0, done=0, err_count=0, dut_d=0. A new start then completes normally with pass=1.
6. start held high during RUN; then start in DONE with a faulty run followed by an ideal run:
   - start held during RUN has no effect and the run still ends at E17.
   - The restart clears the previous err_count=8 at the start edge.
   - The ideal run ends with pass=1 and err_count=0.
